// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit sides: oversampling
// ratio, frame width and the receive state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 8;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        BREAK = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line. Every stage
// resets to 1 so a reset looks like an idle line.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: qualifies the start bit, runs the external
// oversampling counter and assembles LSB-first bytes with stop-bit checking.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HALF_BIT    = OVERSAMPLE / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       count8,
    input  logic       count72,
    output logic       cnt_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] HCNT_LAST = 3'(HALF_BIT - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [2:0]           hcnt_q, hcnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 cnt_en_q, cnt_en_d;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hcnt_q      <= 3'd0;
            sh_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            sh_q        <= sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            cnt_en_q    <= cnt_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        sh_d        = sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        cnt_en_d    = cnt_en_q;

        case (state_q)
            IDLE: begin
                cnt_en_d = 1'b0;
                hcnt_d   = 3'd0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            // Start bit must stay low for half a bit; the counter is then
            // enabled so its origin sits on the start-bit midpoint.
            START: begin
                if (rx_s) begin
                    state_d = IDLE;
                    hcnt_d  = 3'd0;
                end else if (hcnt_q == HCNT_LAST) begin
                    state_d  = DATA;
                    hcnt_d   = 3'd0;
                    cnt_en_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 3'd1;
                end
            end

            // count72 takes priority over count8 when both are raised.
            DATA: begin
                if (count72) begin
                    cnt_en_d = 1'b0;
                    if (rx_s) begin
                        rx_data_d  = sh_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else if (count8) begin
                    sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
                end
            end

            // A line held low must go high before another start is accepted.
            BREAK: begin
                cnt_en_d = 1'b0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_en_d = 1'b0;
            end
        endcase
    end

    assign cnt_en    = cnt_en_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a behavioural oversampling counter, a serial
// line driver, and a scoreboard of expected frame results.
module tb_uart_rx_ctrl;

    localparam int CLK_HALF = 20;
    localparam int CLK_P    = 2 * CLK_HALF;
    localparam int BIT_T    = 8 * CLK_P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       count8;
    logic       count72;
    logic       cnt_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // Expected result per frame: bit 8 = framing error, bits 7:0 = rx_data.
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    always #CLK_HALF clk = ~clk;

    uart_rx_ctrl #(
        .SYNC_STAGES(2),
        .HALF_BIT   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .count8   (count8),
        .count72  (count72),
        .cnt_en   (cnt_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Counter stage: clears while disabled, strobes 8 data midpoints then stop.
    logic [6:0] oc_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) oc_cnt <= 7'd0;
        else if (!cnt_en) oc_cnt <= 7'd0;
        else oc_cnt <= oc_cnt + 7'd1;
    end
    assign count8  = cnt_en && (oc_cnt[2:0] == 3'd7) && (oc_cnt < 7'd64);
    assign count72 = cnt_en && (oc_cnt == 7'd71);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor
    int   en_run = 0;
    logic prev_pulse = 1'b0;
    logic prev_en = 1'b0;
    logic [8:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_run     = 0;
            prev_pulse = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                check("pulse_on_cnt_en_fall", {31'd0, prev_en && !cnt_en}, 32'd1);
                check("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual valid=%0b err=%0b data=%0h required no pulse",
                             rx_valid, frame_err, rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_result", {22'd0, frame_err, rx_valid, rx_data},
                          {22'd0, e[8], ~e[8], e[7:0]});
                end
            end
            if (cnt_en) begin
                en_run++;
            end else if (en_run != 0) begin
                check("cnt_en_high_clocks", en_run, 32'd72);
                en_run = 0;
            end
            prev_pulse = rx_valid || frame_err;
            prev_en    = cnt_en;
        end
    end

    // Driver
    task automatic align();
        @(posedge clk);
        #12;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
        if (stop) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop;
        #(bit_t);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout_pending", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #(4000000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       saw_en;
        logic [7:0] b;
        logic       stop;
        int         bt;
        int         gap;

        // Reset state
        #100;
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_cnt_en", {31'd0, cnt_en}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean frame
        align();
        send_frame(8'hA5, 1'b1, BIT_T);
        wait_drain(200);
        repeat (4) @(negedge clk);
        check("clean_busy_after", {31'd0, busy}, 32'd0);

        // Start glitch
        align();
        rx = 1'b0;
        #(3 * CLK_P);
        rx = 1'b1;
        saw_en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cnt_en) saw_en = 1'b1;
        end
        check("glitch_no_cnt_en", {31'd0, saw_en}, 32'd0);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        // Stop bit low, then line held low
        align();
        exp_q.push_back({1'b1, last_good});
        b = 8'h3C;
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_T);
        end
        rx = 1'b0;
        #(BIT_T);
        #(40 * CLK_P);
        @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd1);
        check("break_cnt_en", {31'd0, cnt_en}, 32'd0);
        check("break_rx_data_held", {24'd0, rx_data}, 32'hA5);
        wait_drain(10);
        align();
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_exit_busy", {31'd0, busy}, 32'd0);

        // Back-to-back frames
        align();
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        wait_drain(200);

        // Reset during bit 4
        align();
        b = 8'h5A;
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_T);
        end
        rx = b[4];
        #(BIT_T / 2);
        rst_n = 1'b0;
        #4;
        check("midreset_cnt_en", {31'd0, cnt_en}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        check("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        last_good = 8'h00;
        rx = 1'b1;
        #(3 * CLK_P);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        align();
        send_frame(8'h5A, 1'b1, BIT_T);
        wait_drain(200);

        // Baud skew both ways
        align();
        send_frame(8'h69, 1'b1, BIT_T + 10);
        wait_drain(200);
        align();
        send_frame(8'h69, 1'b1, BIT_T - 10);
        wait_drain(200);

        // Randomised frames
        align();
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            bt   = BIT_T - 10 + 10 * int'($urandom_range(0, 2));
            gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            send_frame(b, stop, bt);
            #(gap * CLK_P);
        end
        wait_drain(400);
        repeat (10) @(negedge clk);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller of the UART receiver, sitting directly upstream and downstream of the oversampling bit counter. Synchronises the serial `rx` line, detects and qualifies the start bit, drives the counter's `enable`, and consumes its `count8`/`count72` strobes. It shifts in 8 data bits LSB-first, checks the stop bit, and presents the byte with a one-cycle valid pulse or a framing-error pulse. The clock is 8x the baud rate.

## Interface
- `SYNC_STAGES`, 2, number of flops in the `rx` synchroniser (min 2).
- `HALF_BIT`, 4, clocks of continuous low required to qualify a start bit (half of the 8x oversample).
- `clk`  in  1  system clock, 8x baud; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw asynchronous serial line, idle high.
- `count8`  in  1  counter strobe: mid-point of data bits 0..7.
- `count72`  in  1  counter strobe: mid-point of stop bit.
- `cnt_en`  out  1  registered enable to counter; low clears it.
- `rx_data`  out  8  last good received byte; held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Synchroniser: `SYNC_STAGES` flops, all reset to 1; output `rx_s`. All decisions use `rx_s` only.
- States: IDLE, START, DATA, BREAK.
- IDLE:
  - `cnt_en`=0, half-bit counter `hcnt` (3 bits) = 0.
  - `rx_s`==0 → START.
- START:
  - `rx_s`==0 → `hcnt`++.
  - `rx_s`==1 at any point → IDLE (glitch rejected, no output).
  - `rx_s`==0 while `hcnt`==`HALF_BIT`-1 → DATA, with `cnt_en`←1 on that same edge.
- DATA (`cnt_en`=1):
  - `count8`=1 and `count72`=0 → shift register `sh` ← {`rx_s`, `sh`[7:1]} (LSB first).
  - `count72`=1 and `rx_s`=1: `rx_data`←`sh`, `rx_valid`←1, `cnt_en`←0, → IDLE.
  - `count72`=1 and `rx_s`=0: `frame_err`←1, `rx_data` unchanged, `cnt_en`←0, → BREAK.
- BREAK: wait for `rx_s`==1 → IDLE. This prevents a held-low line (break) from retriggering a start.
- `count8`/`count72` are ignored outside DATA. If both are high together, `count72` wins (the counter never does this).
- `busy` = (state != IDLE), combinational from the state register.

## Timing
- Reset values: state IDLE, `cnt_en` 0, `rx_data` 8'h00, `rx_valid` 0, `frame_err` 0, `sh` 0, sync flops 1, `busy` 0.
- Reset asserted mid-frame: the frame is discarded, no pulse is produced, and `cnt_en` drops asynchronously.
- Latency from a `rx` falling edge:
  - `SYNC_STAGES` clocks to `rx_s`.
  - A further `HALF_BIT` clocks to `cnt_en`=1, which places the counter origin at the start-bit midpoint.
- Counter contract: after `cnt_en` rises, the counter pulses `count8` every 8 clocks (8 pulses), then `count72` 8 clocks after the last `count8`. Each pulse falls at a bit midpoint.
- `rx_valid`/`frame_err` rise on the clock edge following the edge that sampled `count72`=1, and last exactly one cycle.
- `cnt_en` falls on that same edge; the counter clears on the next edge, so no stray strobes reach IDLE.
- Back-to-back frames: a new start bit is accepted from IDLE immediately after `rx_valid`. There is no dead cycle beyond the state transition.
- Frame duration, start of start-bit to `rx_valid`: ≈ `SYNC_STAGES` + 76 clocks.

## Structure
- Shared package `uart_pkg`:
  - `OVERSAMPLE`=8 and `DATA_BITS`=8.
  - `rx_state_t` enum (IDLE, START, DATA, BREAK), also reused by the transmit side.
- One sub-module, `uart_sync`: a parameterised `SYNC_STAGES` flop chain with async active-low reset and reset value 1.
- The bench instantiates `uart_rx_ctrl` together with the counter stage, connecting `cnt_en`→`enable` and `count8`/`count72` back.

## Test plan
- Clean frame 0xA5 (1 start, bits 1,0,1,0,0,1,0,1 LSB-first, 1 stop) at 8 clk/bit → `rx_valid` pulse once, `rx_data`=8'hA5, `frame_err`=0, `cnt_en` high for exactly 72 clocks.
- Start glitch: `rx` low for 3 clocks then high → returns to IDLE, `cnt_en` never asserts, no pulses.
- Stop bit low on byte 0x3C → `frame_err` pulse, `rx_data` retains previous 0xA5; `rx` held low 40 more clocks → stays BREAK, `busy`=1; `rx` high → IDLE.
- Back-to-back 0x00 then 0xFF with no idle gap → two `rx_valid` pulses, data 0x00 then 0xFF.
- `rst_n` pulsed low during bit 4 → outputs immediately at reset values, no `rx_valid`; the next clean frame 0x5A is received correctly.
- Baud skew ±3% (bit period 8±0.25 clk via jittered stimulus) on 0x69 → correct `rx_data`=8'h69.
